axil_rr_master_arbiter: RTL and testbench
=========================================

Name: axil_rr_master_arbiter

Overview:
- Shares the single AXI-Lite slave register file (32 x 32-bit registers, 7-bit byte address) between two simple requesters.
- Round-robin arbitration with exactly one transaction outstanding at a time.
- Drives a protocol-clean AXI-Lite master port: VALIDs held until handshake, AW and W tracked independently, BREADY/RREADY asserted only while waiting for a response.
- Sits between the control-plane requesters and the register-file slave.

Parameters:
- ADDR_W, 7, AXI-Lite byte address width.
- DATA_W, 32, data width; WSTRB width is DATA_W/8.
- TIMEOUT_CYCLES, 15, maximum cycles waiting in any AXI phase before an abort; 0 disables the timeout.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request strobe; bit i belongs to requester i.
- req_ready  out  2  one-hot grant; acceptance happens when req_valid[i] & req_ready[i].
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  2*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  packed write data.
- req_wstrb  in  2*DATA_W/8  packed write strobes.
- rsp_valid  out  2  one-cycle response pulse to the owning requester.
- rsp_rdata  out  DATA_W  read data, shared, qualified by rsp_valid.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- M_AXI_AWVALID/AWREADY/AWADDR/AWPROT, M_AXI_WVALID/WREADY/WDATA/WSTRB, M_AXI_BVALID/BREADY/BRESP, M_AXI_ARVALID/ARREADY/ARADDR/ARPROT, M_AXI_RVALID/RREADY/RDATA/RRESP  standard AXI-Lite master channels. PROT outputs are constant 3'b000.

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE; last_grant = 1, so requester 0 wins first.
  - All M_AXI VALIDs, BREADY, RREADY, req_ready and rsp_valid = 0.
  - rsp_rdata = 0, rsp_resp = 0, timeout counter = 0.
- IDLE:
  - req_ready is combinational, one-hot.
  - If only one requester is valid, it is granted.
  - If both are valid, grant the one not equal to last_grant.
  - On acceptance, latch addr/wdata/wstrb/write/owner and update last_grant.
  - Next state is WR_ADDR (write) or RD_ADDR (read).
  - req_ready = 0 in every other state.
- WR_ADDR:
  - AWVALID and WVALID rise in the cycle after acceptance.
  - Each drops independently on its own READY handshake; the other stays asserted.
  - Advance to WR_RESP once both handshakes are done; same-cycle completion is allowed.
- WR_RESP: BREADY = 1; on BVALID capture BRESP and go to RESP.
- RD_ADDR: ARVALID = 1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY = 1; on RVALID capture RDATA/RRESP and go to RESP.
- RESP:
  - rsp_valid[owner] = 1 for exactly one cycle, then return to IDLE.
  - Requester cannot backpressure the response.
  - A new grant is possible the cycle after RESP.
- Address/data/strobe outputs stay stable while the corresponding VALID is high.
- Timeout:
  - Counter clears on every state entry and increments each cycle in WR_ADDR, WR_RESP, RD_ADDR and RD_DATA.
  - At TIMEOUT_CYCLES, drop all VALIDs and READYs and go to RESP with rsp_resp = 2'b10, rsp_rdata = 0.
  - Next state after the abort is IDLE.
- Minimum transaction latency: acceptance to rsp_valid = 3 cycles with a zero-wait slave.
- Reset mid-transaction: all outputs return to reset values immediately; no response is issued to the owner.

Test Plan:
- Write, zero-wait: requester 0 writes addr 0x40, data 0x80000000, wstrb 4'b1000 -> AW/W VALID 1 cycle after acceptance; rsp_valid[0] 3 cycles after acceptance, rsp_resp = 0; slave reg16 = 0x80000000.
- Simultaneous requests: both requesters valid in the first cycle after reset -> requester 0 served first, requester 1 granted in the cycle after requester 0's RESP.
- Skewed handshakes: AWREADY at +1, WREADY at +3 -> AWVALID drops after +1, WVALID stays high until +3; exactly one BREADY handshake.
- Read: requester 1 reads 0x40 after the write -> rsp_rdata = 0x80000000, rsp_valid[1] pulses once.
- Timeout: slave never asserts ARREADY -> after 15 cycles ARVALID drops, rsp_resp = 2'b10, FSM back in IDLE.
- Reset mid-transaction: deassert S_AXI_ARESETN while in WR_RESP -> all outputs 0 immediately; next request after reset completes normally.

Source files
------------

// File: rtl/axil_rr_master_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axil_rr_master_arbiter
// Brief    : Two-requester round-robin front end for a single AXI-Lite master
//            port, one transaction outstanding, with per-phase timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module axil_rr_master_arbiter #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,

    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]     req_wdata,
    input  logic [2*DATA_W/8-1:0]   req_wstrb,
    output logic [1:0]              rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic [1:0]              rsp_resp,

    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [ADDR_W-1:0]       M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    output logic [DATA_W-1:0]       M_AXI_WDATA,
    output logic [DATA_W/8-1:0]     M_AXI_WSTRB,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    input  logic [1:0]              M_AXI_BRESP,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    output logic [ADDR_W-1:0]       M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    input  logic [DATA_W-1:0]       M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       RESP_ABRT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;

    logic [1:0]          w_grant;
    logic                w_sel;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_timeout;
    logic                w_waiting;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_VAL);
    assign w_waiting = (state_q == S_WR_ADDR) || (state_q == S_WR_RESP) ||
                       (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        req_ready     = 2'b00;
        rsp_valid     = 2'b00;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        w_grant       = 2'b00;
        w_sel         = 1'b0;
        w_aw_hs       = 1'b0;
        w_w_hs        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On contention the requester that did not win last time goes first.
                if (req_valid == 2'b11) begin
                    w_grant = last_q ? 2'b01 : 2'b10;
                end else begin
                    w_grant = req_valid;
                end
                req_ready = w_grant;
                w_sel     = w_grant[1];
                if (|w_grant) begin
                    owner_d   = w_sel;
                    last_d    = w_sel;
                    addr_d    = w_sel ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
                    wdata_d   = w_sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    wstrb_d   = w_sel ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write[w_sel] ? S_WR_ADDR : S_RD_ADDR;
                end
            end

            S_WR_ADDR: begin
                if (w_timeout) begin
                    rdata_d = '0;
                    resp_d  = RESP_ABRT;
                    state_d = S_RESP;
                end else begin
                    M_AXI_AWVALID = !aw_done_q;
                    M_AXI_WVALID  = !w_done_q;
                    w_aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
                    w_w_hs        = M_AXI_WVALID && M_AXI_WREADY;
                    aw_done_d     = aw_done_q || w_aw_hs;
                    w_done_d      = w_done_q || w_w_hs;
                    if (aw_done_d && w_done_d) begin
                        state_d = S_WR_RESP;
                    end
                end
            end

            S_WR_RESP: begin
                if (w_timeout) begin
                    rdata_d = '0;
                    resp_d  = RESP_ABRT;
                    state_d = S_RESP;
                end else begin
                    M_AXI_BREADY = 1'b1;
                    if (M_AXI_BVALID) begin
                        rdata_d = '0;
                        resp_d  = M_AXI_BRESP;
                        state_d = S_RESP;
                    end
                end
            end

            S_RD_ADDR: begin
                if (w_timeout) begin
                    rdata_d = '0;
                    resp_d  = RESP_ABRT;
                    state_d = S_RESP;
                end else begin
                    M_AXI_ARVALID = 1'b1;
                    if (M_AXI_ARREADY) begin
                        state_d = S_RD_DATA;
                    end
                end
            end

            S_RD_DATA: begin
                if (w_timeout) begin
                    rdata_d = '0;
                    resp_d  = RESP_ABRT;
                    state_d = S_RESP;
                end else begin
                    M_AXI_RREADY = 1'b1;
                    if (M_AXI_RVALID) begin
                        rdata_d = M_AXI_RDATA;
                        resp_d  = M_AXI_RRESP;
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter restarts on every state change so each phase gets its own budget.
        if ((state_d != state_q) || !w_waiting) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_rr_master_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axil_rr_master_arbiter
// Brief    : Scoreboard bench with a reactive AXI-Lite register-file slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_rr_master_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_resp;
    logic [13:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [31:0] rsp_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [6:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axil_rr_master_arbiter #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(15)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr),
        .M_AXI_AWPROT(awprot), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata),
        .M_AXI_RRESP(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- register-file slave model ----------------
    int          aw_delay = 0, w_delay = 0, aw_cnt, w_cnt;
    bit          ar_block = 0, b_block = 0;
    logic        aw_got, w_got, b_pend, rvalid_q;
    logic [6:0]  aw_addr_l;
    logic [31:0] w_data_l, rdata_q;
    logic [3:0]  w_strb_l;
    logic [31:0] mem [32];
    bit          mem_init = 0;
    int          b_hs = 0;

    wire         aw_hs  = awvalid && awready;
    wire         w_hs   = wvalid && wready;
    wire [6:0]   a_eff  = aw_got ? aw_addr_l : awaddr;
    wire [31:0]  d_eff  = w_got ? w_data_l : wdata;
    wire [3:0]   s_eff  = w_got ? w_strb_l : wstrb;
    wire         do_wr  = (aw_got || aw_hs) && (w_got || w_hs);

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid && (w_cnt >= w_delay);
    assign arready = arvalid && !ar_block;
    assign bvalid  = b_pend && !b_block;
    assign bresp   = 2'b00;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = 2'b00;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 32; k++) mem[k] <= 32'h0;
            mem_init <= 1'b1;
        end else if (do_wr && rst_n) begin
            for (int b = 0; b < 4; b++)
                if (s_eff[b]) mem[a_eff[6:2]][8*b +: 8] <= d_eff[8*b +: 8];
        end
        if (bvalid && bready) b_hs <= b_hs + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            b_pend <= 1'b0; rvalid_q <= 1'b0; rdata_q <= 32'h0;
            aw_addr_l <= 7'h0; w_data_l <= 32'h0; w_strb_l <= 4'h0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= awaddr; end
            if (w_hs)  begin w_got <= 1'b1; w_data_l <= wdata; w_strb_l <= wstrb; end
            if (do_wr) begin aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; end
            if (bvalid && bready) b_pend <= 1'b0;
            if (arvalid && arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= mem[araddr[6:2]];
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          owner;
        bit          wr;
        bit          abort;
        bit [31:0]   rdata;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t      sb_q[$];
    bit [31:0] ref_mem [32];
    bit        expect_abort = 0;
    bit        slow = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t        e;
                    logic [6:0]  a;
                    logic [31:0] d;
                    logic [3:0]  s;
                    a = req_addr[i*7 +: 7];
                    d = req_wdata[i*32 +: 32];
                    s = req_wstrb[i*4 +: 4];
                    e.owner = i; e.wr = req_write[i]; e.abort = expect_abort;
                    e.acc_cyc = cyc; e.chk_lat = !slow; e.rdata = 32'h0;
                    if (req_write[i] && !expect_abort) begin
                        for (int b = 0; b < 4; b++)
                            if (s[b]) ref_mem[a[6:2]][8*b +: 8] = d[8*b +: 8];
                    end else if (!req_write[i]) begin
                        e.rdata = ref_mem[a[6:2]];
                    end
                    sb_q.push_back(e);
                end
            end
            if (rsp_valid != 2'b00) begin
                if (sb_q.size() == 0) begin
                    check_eq("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("rsp_owner", {62'd0, rsp_valid}, 64'd1 << e.owner);
                    check_eq("rsp_resp", {62'd0, rsp_resp}, e.abort ? 64'd2 : 64'd0);
                    if (!e.wr || e.abort)
                        check_eq("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                    if (e.chk_lat)
                        check_eq("rsp_latency", 64'(cyc - e.acc_cyc), 64'd3);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive_req(input int i, input bit wr, input logic [6:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        req_valid[i]          = 1'b1;
        req_write[i]          = wr;
        req_addr[i*7 +: 7]    = a;
        req_wdata[i*32 +: 32] = d;
        req_wstrb[i*4 +: 4]   = s;
    endtask

    task automatic wait_accept(input int i, output int acc);
        acc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) begin
                acc = cyc;
                @(posedge clk); #1;
                req_valid[i] = 1'b0;
                return;
            end
        end
        check_eq("accept_timeout", 64'd0, 64'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic single(input int i, input bit wr, input logic [6:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        int acc;
        drive_req(i, wr, a, d, s);
        wait_accept(i, acc);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, b0, arv;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outs", {21'd0, awvalid, wvalid, bready, arvalid, rready,
                              req_ready, rsp_valid, rsp_resp, rsp_rdata}, 64'd0);
        check_eq("prot", {58'd0, awprot, arprot}, 64'd0);
        rst_n = 1'b1;

        // Contention straight out of reset: requester 0 must win.
        drive_req(0, 1'b1, 7'h40, 32'h8000_0000, 4'b1000);
        drive_req(1, 1'b0, 7'h40, 32'h0, 4'h0);
        #1;
        check_eq("first_grant", {62'd0, req_ready}, 64'd1);
        wait_accept(0, acc0);
        check_eq("aw_w_valid_next", {61'd0, awvalid, wvalid, arvalid}, 64'b110);
        wait_accept(1, acc1);
        check_eq("rr_gap_1", 64'(acc1 - acc0), 64'd4);
        drain();
        check_eq("slave_reg16", {32'd0, mem[16]}, 64'h8000_0000);

        // Partial strobe merge and read-back.
        single(1, 1'b1, 7'h40, 32'hFFFF_FFAA, 4'b0001);
        single(0, 1'b0, 7'h40, 32'h0, 4'h0);

        // last grant is requester 0, so requester 1 wins this contention.
        drive_req(0, 1'b1, 7'h10, 32'h1111_1111, 4'hF);
        drive_req(1, 1'b1, 7'h14, 32'h2222_2222, 4'hF);
        wait_accept(1, acc1);
        wait_accept(0, acc0);
        check_eq("rr_gap_2", 64'(acc0 - acc1), 64'd4);
        drain();

        // Skewed AW/W handshakes.
        slow = 1; w_delay = 2; b0 = b_hs;
        drive_req(0, 1'b1, 7'h08, 32'h1234_5678, 4'hF);
        wait_accept(0, acc0);
        check_eq("skew_t1", {62'd0, awvalid, wvalid}, 64'b11);
        @(posedge clk); #1;
        check_eq("skew_t2", {62'd0, awvalid, wvalid}, 64'b01);
        @(posedge clk); #1;
        check_eq("skew_t3", {62'd0, awvalid, wvalid}, 64'b01);
        @(posedge clk); #1;
        check_eq("skew_t4", {62'd0, awvalid, wvalid}, 64'b00);
        drain();
        check_eq("b_handshakes", 64'(b_hs - b0), 64'd1);
        w_delay = 0; slow = 0;
        single(1, 1'b0, 7'h08, 32'h0, 4'h0);
        single(0, 1'b0, 7'h10, 32'h0, 4'h0);
        single(1, 1'b0, 7'h14, 32'h0, 4'h0);

        // Read address phase never accepted.
        slow = 1; ar_block = 1; expect_abort = 1;
        drive_req(0, 1'b0, 7'h44, 32'h0, 4'h0);
        wait_accept(0, acc0);
        arv = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (arvalid) arv++;
        end
        check_eq("ar_timeout_cycles", 64'(arv), 64'd15);
        drain();
        ar_block = 0; expect_abort = 0; slow = 0;
        single(1, 1'b0, 7'h08, 32'h0, 4'h0);

        // Reset while waiting for the write response.
        slow = 1; b_block = 1;
        drive_req(0, 1'b1, 7'h0C, 32'hDEAD_BEEF, 4'hF);
        wait_accept(0, acc0);
        @(posedge clk); #1;
        check_eq("in_wr_resp", {63'd0, bready}, 64'd1);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_eq("midrst_outs", {21'd0, awvalid, wvalid, bready, arvalid, rready,
                                 req_ready, rsp_valid, rsp_resp, rsp_rdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        b_block = 0; slow = 0;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        single(0, 1'b1, 7'h0C, 32'hCAFE_F00D, 4'hF);
        single(1, 1'b0, 7'h0C, 32'h0, 4'h0);
        single(0, 1'b0, 7'h40, 32'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
